// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL field layout, opcodes, source IDs and slot state
// for the IF/MEM link arbiter.
package tl_ul_pkg;

    localparam int A_W      = 55;
    localparam int D_W      = 47;
    localparam int A_ADDR_W = 10;
    localparam int A_DATA_W = 32;

    localparam int A_OPC_LSB   = 52;
    localparam int A_PARAM_LSB = 49;
    localparam int A_SIZE_LSB  = 46;
    localparam int A_SRC_LSB   = 44;
    localparam int A_ADDR_LSB  = 34;
    localparam int A_DATA_LSB  = 2;
    localparam int A_VALID_BIT = 1;

    localparam int D_OPC_LSB   = 44;
    localparam int D_PARAM_LSB = 42;
    localparam int D_SIZE_LSB  = 37;
    localparam int D_SRC_LSB   = 35;
    localparam int D_ERR_BIT   = 34;
    localparam int D_DATA_LSB  = 2;
    localparam int D_VALID_BIT = 1;

    localparam logic [2:0] OP_GET      = 3'b100;
    localparam logic [2:0] OP_PUT_FULL = 3'b000;
    localparam logic [2:0] OP_ACK      = 3'b000;
    localparam logic [2:0] OP_ACK_DATA = 3'b001;
    localparam logic [2:0] A_SIZE_WORD = 3'b010;

    localparam logic [1:0] SRC_IF  = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_ISSUE,
        SLOT_WAIT,
        SLOT_DONE
    } slot_state_e;

    // Builds a valid A beat; param is always 0 and bit 0 is always 0.
    function automatic logic [A_W-1:0] pack_a(input logic [2:0]          opc,
                                              input logic [1:0]          src,
                                              input logic [A_ADDR_W-1:0] addr,
                                              input logic [A_DATA_W-1:0] data);
        pack_a = {opc, 3'b000, A_SIZE_WORD, src, addr, data, 1'b1, 1'b0};
    endfunction

endpackage

// File: rtl/tl_link_arbiter_if.sv
// Memory-side TileLink-UL link: registered A beat out, D beat in.
interface tl_link_arbiter_if;
    import tl_ul_pkg::*;

    logic [A_W-1:0] a_channel;
    logic           a_ready;
    logic [D_W-1:0] d_channel;
    logic           d_ready;

    modport master (output a_channel, output d_ready, input a_ready, input d_channel);
    modport slave  (input a_channel, input d_ready, output a_ready, output d_channel);

endinterface

// File: rtl/tl_src_slot.sv
// One requester's slot: IDLE/ISSUE/WAIT/DONE FSM, A beat captured at grant,
// response timeout and the done/err/rdata registers seen by the requester.
module tl_src_slot
    import tl_ul_pkg::*;
#(
    parameter int         ADDR_W  = 10,
    parameter int         DATA_W  = 32,
    parameter int         TIMEOUT = 255,
    parameter logic [1:0] SRC     = 2'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              grant,
    input  logic              a_ready,
    input  logic              d_hit,
    input  logic [2:0]        d_opcode,
    input  logic              d_error,
    input  logic [DATA_W-1:0] d_data,
    output slot_state_e       state_o,
    output logic [A_W-1:0]    beat_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    slot_state_e       state_q, state_d;
    logic [A_W-1:0]    beat_q, beat_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        exp_opc;

    assign exp_opc = (beat_q[A_OPC_LSB +: 3] == OP_GET) ? OP_ACK_DATA : OP_ACK;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            SLOT_IDLE: begin
                if (req && grant) begin
                    state_d = SLOT_ISSUE;
                    beat_d  = pack_a(we ? OP_PUT_FULL : OP_GET, SRC, addr,
                                     we ? wdata : '0);
                end
            end
            SLOT_ISSUE: begin
                if (a_ready) begin
                    state_d = SLOT_WAIT;
                    cnt_d   = '0;
                end
            end
            SLOT_WAIT: begin
                // A real response wins over a timeout landing on the same edge.
                if (d_hit) begin
                    state_d = SLOT_DONE;
                    done_d  = 1'b1;
                    err_d   = d_error || (d_opcode != exp_opc);
                    rdata_d = d_data;
                end else if (cnt_q == TO_LAST) begin
                    state_d = SLOT_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SLOT_DONE: state_d = SLOT_IDLE;
            default:   state_d = SLOT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SLOT_IDLE;
            beat_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign state_o = state_q;
    assign beat_o  = beat_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule

// File: rtl/tl_link_arbiter.sv
// Shares one TileLink-UL link between instruction fetch (source 0) and the
// LW/SW port (source 1): round-robin A issue, D routing by source, protocol flag.
module tl_link_arbiter
    import tl_ul_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_done,
    output logic                  if_err,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_done,
    output logic                  mem_err,
    tl_link_arbiter_if.master     link,
    output logic                  proto_err
);

    logic [1:0]        slot_req, slot_we, slot_grant, slot_hit, slot_done, slot_err;
    logic [1:0]        slot_elig, slot_issue, slot_wait;
    logic [ADDR_W-1:0] slot_addr  [2];
    logic [DATA_W-1:0] slot_wdata [2];
    logic [DATA_W-1:0] slot_rdata [2];
    logic [A_W-1:0]    slot_beat  [2];
    slot_state_e       slot_state [2];

    logic              rr_q, rr_d;
    logic              proto_q, proto_d;
    logic              issue_free, d_fire, d_ready_w;
    logic [1:0]        d_src;
    logic [A_W-1:0]    a_channel_w;
    logic              d_unused;

    assign slot_req   = {mem_req, if_req};
    assign slot_we    = {mem_we, 1'b0};
    assign slot_addr  = '{if_addr, mem_addr};
    assign slot_wdata = '{'0, mem_wdata};

    assign d_src  = link.d_channel[D_SRC_LSB +: 2];
    assign d_fire = link.d_channel[D_VALID_BIT] && d_ready_w;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign slot_elig[gi]  = slot_req[gi] && (slot_state[gi] == SLOT_IDLE);
            assign slot_issue[gi] = (slot_state[gi] == SLOT_ISSUE);
            assign slot_wait[gi]  = (slot_state[gi] == SLOT_WAIT);
            assign slot_hit[gi]   = d_fire && (d_src == 2'(gi)) && slot_wait[gi];

            tl_src_slot #(
                .ADDR_W  (ADDR_W),
                .DATA_W  (DATA_W),
                .TIMEOUT (TIMEOUT),
                .SRC     (2'(gi))
            ) u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .req      (slot_req[gi]),
                .we       (slot_we[gi]),
                .addr     (slot_addr[gi]),
                .wdata    (slot_wdata[gi]),
                .grant    (slot_grant[gi]),
                .a_ready  (link.a_ready),
                .d_hit    (slot_hit[gi]),
                .d_opcode (link.d_channel[D_OPC_LSB +: 3]),
                .d_error  (link.d_channel[D_ERR_BIT]),
                .d_data   (link.d_channel[D_DATA_LSB +: DATA_W]),
                .state_o  (slot_state[gi]),
                .beat_o   (slot_beat[gi]),
                .done_o   (slot_done[gi]),
                .err_o    (slot_err[gi]),
                .rdata_o  (slot_rdata[gi])
            );
        end
    endgenerate

    // A slot leaving ISSUE this edge frees the channel, so the other can follow back-to-back.
    assign issue_free = (slot_issue == 2'b00) || link.a_ready;

    always_comb begin
        slot_grant = 2'b00;
        rr_d       = rr_q;
        if (issue_free) begin
            if (slot_elig == 2'b11) begin
                slot_grant = rr_q ? 2'b10 : 2'b01;
                rr_d       = ~rr_q;
            end else begin
                slot_grant = slot_elig;
            end
        end
    end

    always_comb begin
        a_channel_w = '0;
        if (slot_issue[0]) begin
            a_channel_w = slot_beat[0];
        end else if (slot_issue[1]) begin
            a_channel_w = slot_beat[1];
        end
    end

    assign d_ready_w = |slot_wait;
    // Any accepted beat that no waiting slot claims is a protocol violation.
    assign proto_d   = proto_q || (d_fire && (slot_hit == 2'b00));
    assign d_unused  = ^{link.d_channel[D_PARAM_LSB +: 2], link.d_channel[D_SIZE_LSB +: 5],
                         link.d_channel[0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q    <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            proto_q <= proto_d;
        end
    end

    assign link.a_channel = a_channel_w;
    assign link.d_ready   = d_ready_w;
    assign proto_err      = proto_q;
    assign if_done        = slot_done[0];
    assign if_err         = slot_err[0];
    assign if_rdata       = slot_rdata[0];
    assign mem_done       = slot_done[1];
    assign mem_err        = slot_err[1];
    assign mem_rdata      = slot_rdata[1];

endmodule

// File: tb/tb_tl_link_arbiter.sv
// Directed bench for tl_link_arbiter: a transaction-level model checked every
// cycle, plus literal expectations for the headline scenarios.
module tb_tl_link_arbiter;
    import tl_ul_pkg::*;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [9:0]  if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done, if_err;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [9:0]  mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_done, mem_err;
    logic        proto_err;

    tl_link_arbiter_if link();

    tl_link_arbiter #(.ADDR_W(10), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_err    (if_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .mem_err   (mem_err),
        .link      (link),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc_n = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Transaction-level model: each source has at most one transaction, which
    // is queued for the link, then outstanding, then reported for one cycle.
    bit [1:0]    m_busy, m_in_a, m_out, m_done, m_err;
    logic [31:0] m_rdata [2];
    logic [54:0] m_beat [2];
    int          m_deadline [2];
    bit          m_rr, m_proto;

    always @(posedge clk) begin : model
        bit a_v, a_fire, d_rdy, free;
        bit [1:0] fin, ferr, el, gr;
        logic [31:0] frd [2];
        logic [1:0] dsrc;
        logic [2:0] want;
        int who;
        cyc_n++;
        if (!rst_n) begin
            m_busy = '0; m_in_a = '0; m_out = '0; m_done = '0; m_err = '0;
            m_rr = 1'b0; m_proto = 1'b0;
        end else begin
            a_v    = |m_in_a;
            who    = m_in_a[0] ? 0 : 1;
            a_fire = a_v && link.a_ready;
            d_rdy  = |m_out;
            fin = '0; ferr = '0; frd[0] = '0; frd[1] = '0;
            if (link.d_channel[1] && d_rdy) begin
                dsrc = link.d_channel[36:35];
                if (dsrc > 2'd1 || !m_out[dsrc[0]]) begin
                    m_proto = 1'b1;
                end else begin
                    want = (m_beat[dsrc[0]][54:52] == 3'b100) ? 3'b001 : 3'b000;
                    fin[dsrc[0]]  = 1'b1;
                    ferr[dsrc[0]] = link.d_channel[34] || (link.d_channel[46:44] != want);
                    frd[dsrc[0]]  = link.d_channel[33:2];
                end
            end
            for (int s = 0; s < 2; s++) begin
                if (m_out[s] && !fin[s] && cyc_n == m_deadline[s]) begin
                    fin[s] = 1'b1; ferr[s] = 1'b1; frd[s] = '0;
                end
            end
            el   = {mem_req && !m_busy[1], if_req && !m_busy[0]};
            free = !a_v || a_fire;
            gr   = '0;
            if (free) begin
                if (el == 2'b11) begin
                    gr[m_rr] = 1'b1;
                    m_rr = !m_rr;
                end else begin
                    gr = el;
                end
            end
            for (int s = 0; s < 2; s++) begin
                if (m_done[s]) m_busy[s] = 1'b0;
                m_done[s] = 1'b0;
            end
            if (a_fire) begin
                m_in_a[who] = 1'b0;
                m_out[who]  = 1'b1;
                m_deadline[who] = cyc_n + TIMEOUT;
            end
            for (int s = 0; s < 2; s++) begin
                if (fin[s]) begin
                    m_out[s] = 1'b0; m_done[s] = 1'b1; m_err[s] = ferr[s]; m_rdata[s] = frd[s];
                end
            end
            if (gr[0]) begin
                m_busy[0] = 1'b1; m_in_a[0] = 1'b1;
                m_beat[0] = {3'b100, 3'b000, 3'b010, 2'd0, if_addr, 32'h0, 1'b1, 1'b0};
            end
            if (gr[1]) begin
                m_busy[1] = 1'b1; m_in_a[1] = 1'b1;
                m_beat[1] = {mem_we ? 3'b000 : 3'b100, 3'b000, 3'b010, 2'd1, mem_addr,
                             mem_we ? mem_wdata : 32'h0, 1'b1, 1'b0};
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [54:0] exp_a;
        if (chk_en) begin
            exp_a = m_in_a[0] ? m_beat[0] : (m_in_a[1] ? m_beat[1] : 55'h0);
            chk("a_channel", link.a_channel, exp_a);
            chk("d_ready", link.d_ready, |m_out);
            chk("if_done", if_done, m_done[0]);
            chk("mem_done", mem_done, m_done[1]);
            chk("proto_err", proto_err, m_proto);
            if (m_done[0]) begin
                chk("if_err", if_err, m_err[0]);
                if (!m_err[0]) chk("if_rdata", if_rdata, m_rdata[0]);
            end
            if (m_done[1]) begin
                chk("mem_err", mem_err, m_err[1]);
                if (!m_err[1]) chk("mem_rdata", mem_rdata, m_rdata[1]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (if_done) if_req = 1'b0;
        if (mem_done) mem_req = 1'b0;
    endtask

    task automatic send_d(input logic [1:0] src, input logic [2:0] op, input logic err,
                          input logic [31:0] data);
        link.d_channel = {op, 2'b00, 5'd2, src, err, data, 1'b1, 1'b0};
        cyc();
        link.d_channel = '0;
    endtask

    initial begin
        int n;
        link.a_ready   = 1'b0;
        link.d_channel = '0;
        repeat (3) cyc();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("rst_a_channel", link.a_channel, 0);
        chk("rst_d_ready", link.d_ready, 0);
        chk("rst_proto", proto_err, 0);

        // Single LW; req is first seen in cycle 1, done shows in cycle 4.
        link.a_ready = 1'b1;
        mem_we = 1'b0; mem_addr = 10'h3A4; mem_req = 1'b1;
        n = 0;
        cyc(); n++;
        chk("lw_a_beat", link.a_channel, {3'b100, 3'b000, 3'b010, 2'b01, 10'h3A4, 32'h0, 1'b1, 1'b0});
        cyc(); n++;
        chk("lw_d_ready", link.d_ready, 1);
        send_d(2'd1, 3'b001, 1'b0, 32'hDEADBEEF); n++;
        chk("lw_done", mem_done, 1);
        chk("lw_rdata", mem_rdata, 32'hDEADBEEF);
        chk("lw_err", mem_err, 0);
        chk("lw_latency_edges", n, 3);
        cyc();

        // Contested pair from reset pointer: IF, then MEM back-to-back.
        if_addr = 10'h010; mem_addr = 10'h020; if_req = 1'b1; mem_req = 1'b1;
        cyc();
        chk("pair1_first_src", link.a_channel[45:44], 2'd0);
        cyc();
        chk("pair1_second_src", link.a_channel[45:44], 2'd1);
        send_d(2'd0, 3'b001, 1'b0, 32'h0BADF00D);
        chk("pair1_if_done", if_done, 1);
        chk("pair1_if_rdata", if_rdata, 32'h0BADF00D);
        send_d(2'd1, 3'b000, 1'b0, 32'h1);
        chk("pair1_badop_err", mem_err, 1);
        cyc();

        // Second contested pair: MEM first; answers return out of order.
        if_addr = 10'h011; mem_addr = 10'h021; if_req = 1'b1; mem_req = 1'b1;
        cyc();
        chk("pair2_first_src", link.a_channel[45:44], 2'd1);
        cyc();
        chk("pair2_second_src", link.a_channel[45:44], 2'd0);
        cyc();
        send_d(2'd1, 3'b001, 1'b0, 32'hAAAA5555);
        chk("ooo_mem_done", mem_done, 1);
        chk("ooo_mem_rdata", mem_rdata, 32'hAAAA5555);
        chk("ooo_if_quiet", if_done, 0);
        send_d(2'd0, 3'b001, 1'b0, 32'h5555AAAA);
        chk("ooo_if_rdata", if_rdata, 32'h5555AAAA);
        cyc();

        // SW stalled by a_ready=0 for 5 cycles; inputs change but the beat must not.
        link.a_ready = 1'b0;
        mem_we = 1'b1; mem_addr = 10'h155; mem_wdata = 32'h12345678; mem_req = 1'b1;
        cyc();
        for (int i = 0; i < 6; i++) begin
            chk("sw_stall_beat", link.a_channel,
                {3'b000, 3'b000, 3'b010, 2'b01, 10'h155, 32'h12345678, 1'b1, 1'b0});
            mem_addr = 10'h2AA; mem_wdata = 32'hFFFF0000;
            if (i == 5) link.a_ready = 1'b1;
            cyc();
        end
        chk("sw_issued", link.d_ready, 1);
        send_d(2'd1, 3'b000, 1'b0, 32'h0);
        chk("sw_done", mem_done, 1);
        chk("sw_err", mem_err, 0);
        cyc();

        // SW answered with d_error.
        mem_addr = 10'h0F0; mem_wdata = 32'hCAFEF00D; mem_req = 1'b1;
        cyc(); cyc();
        send_d(2'd1, 3'b000, 1'b1, 32'h0);
        chk("sw_derr_done", mem_done, 1);
        chk("sw_derr_err", mem_err, 1);
        cyc();

        // Source-3 beat while IF waits: flagged and dropped.
        if_addr = 10'h044; if_req = 1'b1;
        cyc(); cyc();
        send_d(2'd3, 3'b001, 1'b0, 32'h77);
        chk("src3_proto", proto_err, 1);
        chk("src3_no_done", if_done, 0);
        send_d(2'd0, 3'b001, 1'b0, 32'h99);
        chk("src3_if_done", if_done, 1);
        cyc();

        // Reset with a MEM load outstanding abandons it and clears proto_err.
        mem_we = 1'b0; mem_addr = 10'h0AA; mem_req = 1'b1;
        cyc(); cyc();
        mem_req = 1'b0; rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        chk("rst2_proto", proto_err, 0);
        chk("rst2_d_ready", link.d_ready, 0);

        // Fetch never answered: times out after 255 cycles in WAIT.
        if_addr = 10'h3FF; if_req = 1'b1;
        cyc(); cyc();
        n = 0;
        while (!if_done && n < 300) begin
            cyc(); n++;
        end
        chk("timeout_cycles", n, 255);
        chk("timeout_err", if_err, 1);
        cyc();

        // Late IF response while MEM waits is a protocol error; MEM still completes.
        mem_we = 1'b0; mem_addr = 10'h100; mem_req = 1'b1;
        cyc(); cyc();
        send_d(2'd0, 3'b001, 1'b0, 32'h1234);
        chk("late_proto", proto_err, 1);
        chk("late_no_if_done", if_done, 0);
        send_d(2'd1, 3'b001, 1'b0, 32'h4321);
        chk("late_mem_rdata", mem_rdata, 32'h4321);
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
